// File: rtl/dmem_arb.sv
// dmem_arb: two-requester arbiter and access sequencer for the FFT dual-port
// data memory. The engine has priority and a starvation counter bounds how
// long the host can be held off. All memory-side pins are registered, and read
// data comes back two cycles after the accept edge through a two-stage tag
// pipeline.
module dmem_arb #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // host lane (port 1 only)
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  // engine lanes (lane 0 -> port 1, lane 1 -> port 2)
  input  logic              eng_req,
  input  logic [1:0]        eng_en,
  input  logic [1:0]        eng_we,
  input  logic [ADDR_W-1:0] eng_addr0,
  input  logic [ADDR_W-1:0] eng_addr1,
  input  logic [DATA_W-1:0] eng_wdata0,
  input  logic [DATA_W-1:0] eng_wdata1,
  output logic              eng_gnt,
  output logic [1:0]        eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata0,
  output logic [DATA_W-1:0] eng_rdata1,
  // memory port 1
  output logic              mem_csb1,
  output logic              mem_web1,
  output logic              mem_oeb1,
  output logic [ADDR_W-1:0] mem_a1,
  output logic [DATA_W-1:0] mem_i1,
  input  logic [DATA_W-1:0] mem_o1,
  // memory port 2
  output logic              mem_csb2,
  output logic              mem_web2,
  output logic              mem_oeb2,
  output logic [ADDR_W-1:0] mem_a2,
  output logic [DATA_W-1:0] mem_i2,
  input  logic [DATA_W-1:0] mem_o2,
  output logic              coll_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              force_host_s;
  logic              eng_gnt_s;
  logic              host_gnt_s;
  logic              coll_s;
  logic              p1_act_s;
  logic              p1_we_s;
  logic [ADDR_W-1:0] p1_addr_s;
  logic [DATA_W-1:0] p1_data_s;
  logic              p2_act_s;

  logic [3:0]        starve_cnt_r;
  // stage 1: issue cycle (mem pins active); stage 2: oeb-low cycle
  logic              s1_host_r;
  logic [1:0]        s1_rd_r;
  logic              s2_host_r;
  logic [1:0]        s2_rd_r;

  // Grant decision, collision detection and port-1 source selection.
  always_comb begin
    force_host_s = (starve_cnt_r == STARVE_LIM);
    eng_gnt_s    = rst_n & eng_req & (eng_en != 2'b00) & ~force_host_s;
    host_gnt_s   = rst_n & host_req & ~eng_gnt_s;
    // lane 1 is dropped when both lanes hit one word and either one writes
    coll_s       = eng_gnt_s & (eng_en == 2'b11) & (eng_addr0 == eng_addr1)
                   & (eng_we != 2'b00);
    p2_act_s     = eng_gnt_s & eng_en[1] & ~coll_s;
    if (host_gnt_s) begin
      p1_act_s  = 1'b1;
      p1_we_s   = host_we;
      p1_addr_s = host_addr;
      p1_data_s = host_wdata;
    end else begin
      p1_act_s  = eng_gnt_s & eng_en[0];
      p1_we_s   = eng_we[0];
      p1_addr_s = eng_addr0;
      p1_data_s = eng_wdata0;
    end
  end

  assign host_gnt = host_gnt_s;
  assign eng_gnt  = eng_gnt_s;

  // Starvation counter: counts denied host cycles, saturates, clears on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if (host_gnt_s) begin
      starve_cnt_r <= 4'd0;
    end else if (host_req && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Port 1 control/address/data registers; a and i hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_csb1 <= 1'b1;
      mem_web1 <= 1'b1;
      mem_a1   <= '0;
      mem_i1   <= '0;
    end else if (p1_act_s) begin
      mem_csb1 <= 1'b0;
      mem_web1 <= ~p1_we_s;
      mem_a1   <= p1_addr_s;
      mem_i1   <= p1_data_s;
    end else begin
      mem_csb1 <= 1'b1;
      mem_web1 <= 1'b1;
    end
  end

  // Port 2 control/address/data registers; only engine lane 1 reaches port 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_csb2 <= 1'b1;
      mem_web2 <= 1'b1;
      mem_a2   <= '0;
      mem_i2   <= '0;
    end else if (p2_act_s) begin
      mem_csb2 <= 1'b0;
      mem_web2 <= ~eng_we[1];
      mem_a2   <= eng_addr1;
      mem_i2   <= eng_wdata1;
    end else begin
      mem_csb2 <= 1'b1;
      mem_web2 <= 1'b1;
    end
  end

  // Read tag pipeline and output enables; oeb is low in the cycle after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_host_r <= 1'b0;
      s1_rd_r   <= 2'b00;
      s2_host_r <= 1'b0;
      s2_rd_r   <= 2'b00;
      mem_oeb1  <= 1'b1;
      mem_oeb2  <= 1'b1;
      coll_err  <= 1'b0;
    end else begin
      s1_host_r <= host_gnt_s;
      s1_rd_r   <= {p2_act_s & ~eng_we[1], p1_act_s & ~p1_we_s};
      s2_host_r <= s1_host_r;
      s2_rd_r   <= s1_rd_r;
      mem_oeb1  <= ~s1_rd_r[0];
      mem_oeb2  <= ~s1_rd_r[1];
      coll_err  <= coll_s;
    end
  end

  // Read return: capture mem_o at the end of the oeb-low cycle, pulse rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rvalid <= 1'b0;
      eng_rvalid  <= 2'b00;
      host_rdata  <= '0;
      eng_rdata0  <= '0;
      eng_rdata1  <= '0;
    end else begin
      host_rvalid <= s2_host_r & s2_rd_r[0];
      eng_rvalid  <= s2_host_r ? 2'b00 : s2_rd_r;
      if (s2_host_r && s2_rd_r[0]) begin
        host_rdata <= mem_o1;
      end else begin
        host_rdata <= host_rdata;
      end
      if (!s2_host_r && s2_rd_r[0]) begin
        eng_rdata0 <= mem_o1;
      end else begin
        eng_rdata0 <= eng_rdata0;
      end
      if (!s2_host_r && s2_rd_r[1]) begin
        eng_rdata1 <= mem_o2;
      end else begin
        eng_rdata1 <= eng_rdata1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: a word-array reference model predicts
// grants, pin activity and read data; a separate monitor pops expected
// responses whenever the DUT raises an rvalid.
module tb_dmem_arb;
  localparam int AW = 4;
  localparam int DW = 128;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          eng_req = 1'b0;
  logic [1:0]    eng_en = 2'b00, eng_we = 2'b00;
  logic [AW-1:0] eng_addr0 = '0, eng_addr1 = '0;
  logic [DW-1:0] eng_wdata0 = '0, eng_wdata1 = '0;
  logic          eng_gnt;
  logic [1:0]    eng_rvalid;
  logic [DW-1:0] eng_rdata0, eng_rdata1;
  logic          mem_csb1, mem_web1, mem_oeb1, mem_csb2, mem_web2, mem_oeb2;
  logic [AW-1:0] mem_a1, mem_a2;
  logic [DW-1:0] mem_i1, mem_i2, mem_o1, mem_o2;
  logic          coll_err;

  dmem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .eng_req(eng_req), .eng_en(eng_en), .eng_we(eng_we),
    .eng_addr0(eng_addr0), .eng_addr1(eng_addr1),
    .eng_wdata0(eng_wdata0), .eng_wdata1(eng_wdata1), .eng_gnt(eng_gnt),
    .eng_rvalid(eng_rvalid), .eng_rdata0(eng_rdata0), .eng_rdata1(eng_rdata1),
    .mem_csb1(mem_csb1), .mem_web1(mem_web1), .mem_oeb1(mem_oeb1),
    .mem_a1(mem_a1), .mem_i1(mem_i1), .mem_o1(mem_o1),
    .mem_csb2(mem_csb2), .mem_web2(mem_web2), .mem_oeb2(mem_oeb2),
    .mem_a2(mem_a2), .mem_i2(mem_i2), .mem_o2(mem_o2),
    .coll_err(coll_err)
  );

  always #5 clk = ~clk;

  // Dual-port SRAM model: clocked on CE = clk, data driven while oeb is low.
  logic [DW-1:0] smem [16];
  logic [DW-1:0] dout1 = '0, dout2 = '0;
  always @(posedge clk) begin
    if (!mem_csb1) begin
      if (!mem_web1) smem[mem_a1] <= mem_i1;
      else           dout1 <= smem[mem_a1];
    end
    if (!mem_csb2) begin
      if (!mem_web2) smem[mem_a2] <= mem_i2;
      else           dout2 <= smem[mem_a2];
    end
  end
  assign mem_o1 = mem_oeb1 ? '0 : dout1;
  assign mem_o2 = mem_oeb2 ? '0 : dout2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int due; } hexp_t;
  typedef struct { logic [1:0] m; logic [DW-1:0] d0; logic [DW-1:0] d1; int due; } eexp_t;
  hexp_t hq[$];
  eexp_t eq[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] ref_mem [16];
  int starve = 0;
  bit m_hgnt = 1'b0, m_egnt = 1'b0;
  bit exp_csb1 = 1'b1, exp_csb2 = 1'b1, exp_web1 = 1'b1, exp_web2 = 1'b1;
  bit exp_coll = 1'b0;
  bit rd1_p0 = 1'b0, rd1_p1 = 1'b0, rd2_p0 = 1'b0, rd2_p1 = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: pop and compare expected read responses as the DUT returns them.
  hexp_t he;
  eexp_t ee;
  always @(negedge clk) begin
    if (rst_n) begin
      if (host_rvalid) begin
        if (hq.size() == 0) begin
          chk("host_rvalid_unexpected", 1'b1, 1'b0);
        end else begin
          he = hq.pop_front();
          chk("host_rdata", host_rdata, he.d);
          chk("host_rlatency", cyc, he.due);
        end
      end else if (hq.size() != 0 && hq[0].due < cyc) begin
        he = hq.pop_front();
        chk("host_rvalid_missing", 1'b0, 1'b1);
      end
      if (eng_rvalid != 2'b00) begin
        if (eq.size() == 0) begin
          chk("eng_rvalid_unexpected", eng_rvalid, 2'b00);
        end else begin
          ee = eq.pop_front();
          chk("eng_rvalid_mask", eng_rvalid, ee.m);
          chk("eng_rlatency", cyc, ee.due);
          if (ee.m[0]) chk("eng_rdata0", eng_rdata0, ee.d0);
          if (ee.m[1]) chk("eng_rdata1", eng_rdata1, ee.d1);
        end
      end else if (eq.size() != 0 && eq[0].due < cyc) begin
        ee = eq.pop_front();
        chk("eng_rvalid_missing", 2'b00, ee.m);
      end
    end
  end

  // One cycle: check pins from earlier issues, drive, check grants, update model.
  task automatic step(input bit hr, input bit hw, input logic [AW-1:0] ha,
                      input logic [DW-1:0] hd, input bit er, input logic [1:0] en,
                      input logic [1:0] ew, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1);
    bit eg, hg, coll, p1, p1w, p2;
    logic [1:0] mask;
    @(negedge clk);
    chk("mem_csb1", mem_csb1, exp_csb1);
    chk("mem_web1", mem_web1, exp_web1);
    chk("mem_csb2", mem_csb2, exp_csb2);
    chk("mem_web2", mem_web2, exp_web2);
    chk("mem_oeb1", mem_oeb1, !rd1_p1);
    chk("mem_oeb2", mem_oeb2, !rd2_p1);
    chk("coll_err", coll_err, exp_coll);
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    eng_req = er; eng_en = en; eng_we = ew; eng_addr0 = a0; eng_addr1 = a1;
    eng_wdata0 = d0; eng_wdata1 = d1;
    #1;
    eg = er && (en != 2'b00) && (starve != SM);
    hg = hr && !eg;
    chk("eng_gnt", eng_gnt, eg);
    chk("host_gnt", host_gnt, hg);
    coll = eg && (en == 2'b11) && (a0 == a1) && (ew != 2'b00);
    if (hg) begin p1 = 1'b1; p1w = hw; end
    else begin p1 = eg && en[0]; p1w = ew[0]; end
    p2 = eg && en[1] && !coll;
    if (hg && !hw) hq.push_back(hexp_t'{ref_mem[ha], cyc + 3});
    if (eg) begin
      mask = {p2 && !ew[1], en[0] && !ew[0]};
      if (mask != 2'b00) eq.push_back(eexp_t'{mask, ref_mem[a0], ref_mem[a1], cyc + 3});
    end
    if (hg && hw) ref_mem[ha] = hd;
    if (eg && en[0] && ew[0]) ref_mem[a0] = d0;
    if (p2 && ew[1]) ref_mem[a1] = d1;
    exp_csb1 = !p1; exp_web1 = !(p1 && p1w);
    exp_csb2 = !p2; exp_web2 = !(p2 && ew[1]);
    exp_coll = coll;
    rd1_p1 = rd1_p0; rd1_p0 = p1 && !p1w;
    rd2_p1 = rd2_p0; rd2_p0 = p2 && !ew[1];
    if (hg) starve = 0;
    else if (hr && starve < SM) starve++;
    m_hgnt = hg; m_egnt = eg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  // Assert reset between edges, check immediate pin state, flush the model.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; host_req = 1'b1; eng_req = 1'b1; eng_en = 2'b11;
    #1;
    chk("rst_csb1", mem_csb1, 1'b1); chk("rst_web1", mem_web1, 1'b1); chk("rst_oeb1", mem_oeb1, 1'b1);
    chk("rst_csb2", mem_csb2, 1'b1); chk("rst_web2", mem_web2, 1'b1); chk("rst_oeb2", mem_oeb2, 1'b1);
    chk("rst_a1", mem_a1, '0); chk("rst_i1", mem_i1, '0);
    chk("rst_a2", mem_a2, '0); chk("rst_i2", mem_i2, '0);
    chk("rst_host_gnt", host_gnt, 1'b0); chk("rst_eng_gnt", eng_gnt, 1'b0);
    chk("rst_host_rvalid", host_rvalid, 1'b0); chk("rst_eng_rvalid", eng_rvalid, 2'b00);
    chk("rst_host_rdata", host_rdata, '0); chk("rst_coll_err", coll_err, 1'b0);
    hq.delete(); eq.delete(); starve = 0;
    exp_csb1 = 1'b1; exp_csb2 = 1'b1; exp_web1 = 1'b1; exp_web2 = 1'b1; exp_coll = 1'b0;
    rd1_p0 = 1'b0; rd1_p1 = 1'b0; rd2_p0 = 1'b0; rd2_p1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    host_req = 1'b0; eng_req = 1'b0; eng_en = 2'b00;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] pat_a5, da, db;
  int denied;
  bit done;
  bit hr, hw, er, hp, ep;
  logic [AW-1:0] ha, a0, a1;
  logic [1:0] en, ew;
  logic [DW-1:0] hd, d0, d1;

  initial begin
    pat_a5 = {16{8'hA5}};
    do_reset();
    // preload every word with dual engine writes
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, 2'b11, 2'b11, 4'(2 * i), 4'(2 * i + 1), rnd128(), rnd128());
    // host write then read at addr 3
    step(1'b1, 1'b1, 4'd3, pat_a5, 1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    step(1'b1, 1'b0, 4'd3, '0, 1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    idle(4);
    // engine dual read 5 / 9
    step(1'b0, 1'b0, '0, '0, 1'b1, 2'b11, 2'b00, 4'd5, 4'd9, '0, '0);
    idle(4);
    // starvation: two rounds, host must win after SM denials each time
    for (int r = 0; r < 2; r++) begin
      denied = 0; done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        step(1'b1, 1'b0, 4'd3, '0, 1'b1, 2'b01, 2'b00, 4'd2, 4'd0, '0, '0);
        if (m_hgnt) done = 1'b1;
        else denied++;
      end
      chk("starve_denied", denied, SM);
    end
    idle(4);
    // collision: write lane 0, read lane 1, same address 7
    da = rnd128(); db = rnd128();
    step(1'b0, 1'b0, '0, '0, 1'b1, 2'b11, 2'b01, 4'd7, 4'd7, da, db);
    idle(4);
    // two reads of the same word are allowed
    step(1'b0, 1'b0, '0, '0, 1'b1, 2'b11, 2'b00, 4'd7, 4'd7, '0, '0);
    idle(4);
    // back-to-back engine reads at addr 2
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1, 2'b01, 2'b00, 4'd2, '0, '0, '0);
    idle(5);
    // reset one cycle after a read grant; no stale rvalid afterwards
    step(1'b1, 1'b0, 4'd3, '0, 1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    do_reset();
    idle(5);
    step(1'b1, 1'b0, 4'd3, '0, 1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    idle(4);
    // randomized traffic with requests held until granted
    hp = 1'b0; ep = 1'b0;
    hr = 1'b0; hw = 1'b0; ha = '0; hd = '0;
    er = 1'b0; en = 2'b00; ew = 2'b00; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hp) begin
        hr = ($urandom_range(0, 2) == 0);
        hw = 1'($urandom_range(0, 1));
        ha = 4'($urandom_range(0, 15));
        hd = rnd128();
      end
      if (!ep) begin
        er = ($urandom_range(0, 2) != 0);
        en = 2'($urandom_range(0, 3));
        ew = 2'($urandom_range(0, 3));
        a0 = 4'($urandom_range(0, 15));
        a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
        d0 = rnd128();
        d1 = rnd128();
      end
      step(hr, hw, ha, hd, er, en, ew, a0, a1, d0, d1);
      hp = hr && !m_hgnt;
      ep = er && (en != 2'b00) && !m_egnt;
    end
    idle(6);
    chk("host_queue_drained", hq.size(), 0);
    chk("eng_queue_drained", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
# dmem_arb

Two-requester arbiter and access sequencer for the dual-port data memory of the FFT accelerator. It sits between the host load/unload path (single lane) and the FFT butterfly engine (two lanes), and drives the active-low SRAM control pins of both dmem ports. It grants one requester per cycle, registers all memory-side signals, and returns read data with a fixed latency. A starvation counter bounds host wait time behind the engine.

## Interface
- ADDR_W, 4, dmem word address width (16 words)
- DATA_W, 128, dmem word width per port
- STARVE_MAX, 4, consecutive denied host cycles before the host is forced to win (1..15)
- clk  in  1  system clock; dmem CE1/CE2 are tied to clk outside this block
- rst_n  in  1  asynchronous active-low reset
- host_req  in  1  host access request, held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address (port 1)
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  combinational; request accepted at this clock edge
- host_rvalid  out  1  host read data valid, one-cycle pulse
- host_rdata  out  DATA_W  host read data
- eng_req  in  1  engine access request, held until granted
- eng_en  in  2  lane enables: bit0 = port 1, bit1 = port 2
- eng_we  in  2  per-lane write
- eng_addr0, eng_addr1  in  ADDR_W each  lane addresses
- eng_wdata0, eng_wdata1  in  DATA_W each  lane write data
- eng_gnt  out  1  combinational; request accepted at this clock edge
- eng_rvalid  out  2  per-lane read data valid, one-cycle pulse
- eng_rdata0, eng_rdata1  out  DATA_W each  lane read data
- mem_csb1, mem_web1, mem_oeb1  out  1 each  port 1 chip select, write enable, output enable (active-low)
- mem_a1  out  ADDR_W  port 1 address;  mem_i1  out  DATA_W  port 1 write data;  mem_o1  in  DATA_W  port 1 read data
- mem_csb2, mem_web2, mem_oeb2, mem_a2, mem_i2, mem_o2: same for port 2
- coll_err  out  1  one-cycle pulse: engine lane-2 access dropped due to address collision

## Operation
- Exactly one requester is granted per cycle. A request with eng_en = 0 is never granted.
- Default priority is the engine: eng_gnt = eng_req & (eng_en != 0) & ~force_host; host_gnt = host_req & ~eng_gnt.
- starve_cnt (4 bits): +1 on each cycle with host_req & ~host_gnt, saturating at STARVE_MAX; cleared on host_gnt. force_host = (starve_cnt == STARVE_MAX).
- A host grant uses port 1 only; port 2 stays deselected that cycle.
- An engine grant drives port 1 from lane 0 when eng_en[0] is set, and port 2 from lane 1 when eng_en[1] is set.
- Collision: if both lanes are enabled, eng_addr0 == eng_addr1, and either eng_we bit is 1, lane 1 is suppressed: port 2 stays deselected, eng_rvalid[1] is not produced, and coll_err pulses in the issue cycle. Two reads to the same address are allowed.
- The memory side is registered. Per port, at a grant edge: csb = 0, web = ~we, a/i loaded. At any edge without an access: csb = 1, web = 1; a and i hold their values.
- oeb = 0 only during the cycle after a read issue cycle on that port; otherwise 1.
- Read return uses a 2-stage tag pipeline (owner, lane mask). rdata is captured from mem_o at the end of the oeb-low cycle, and rvalid pulses for the owner and lanes.
- Write data from the host is not routed to port 2. The host has no visibility of port 2.

## Timing
- Edge E0: request and grant sampled. Cycle E0–E1: mem signals active. E1: SRAM samples (CE = clk). Cycle E1–E2: oeb low, mem_o valid. E2: rdata/rvalid registered.
- Read latency: rvalid is high in the cycle after E2, i.e. 2 cycles after the accept edge. Back-to-back grants give one return per cycle.
- Writes complete at E1. A read issued at the next grant edge returns the new data.
- Worst-case host wait under continuous engine traffic: STARVE_MAX denied cycles, then granted.
- Reset (async, any time):
  - mem_csb*/web*/oeb* = 1; mem_a* = 0; mem_i* = 0.
  - gnt outputs are 0 while reset is asserted.
  - rvalid = 0, rdata = 0, starve_cnt = 0, coll_err = 0.
  - In-flight reads are discarded and no rvalid is produced after reset release.
- Simultaneous host and engine request with starve_cnt < STARVE_MAX: the engine wins.

## Test plan
- Host write 0xA5…A5 to addr 3, then host read addr 3 (no engine traffic) -> host_gnt on both requests, mem_csb1/web1 = 0/0 then 0/1, host_rvalid 2 cycles after the read grant with rdata 0xA5…A5; port 2 csb stays 1.
- Engine dual read, addr0 = 5 and addr1 = 9, both preloaded -> both ports selected in the same cycle, eng_rvalid = 2'b11 2 cycles later with the correct data on each lane.
- Engine eng_req held continuously, host_req raised, STARVE_MAX = 4 -> host denied 4 cycles and granted on the 5th, engine denied that cycle, starve_cnt back to 0.
- Engine collision: write lane 0 and read lane 1, both at addr 7 -> port 2 csb stays 1, coll_err pulses once, only the lane-0 write occurs, no eng_rvalid[1].
- Engine reads at addr 2 issued every cycle for 4 cycles -> 4 consecutive eng_rvalid pulses, oeb1 low for 4 consecutive cycles starting 1 cycle after the first grant.
- rst_n asserted one cycle after a read grant -> all csb/web/oeb go to 1 immediately, no rvalid after release, next read returns correctly.
